// File: rtl/pt8211_stereo_fifo_tx_if.sv
// Sample-pair stream feeding the stereo DAC transmitter.
// The producer (synth/mixer) is the master; the transmitter is the slave.
interface pt8211_stereo_fifo_tx_if #(parameter int DATA_W = 16);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;

  modport master (output s_valid, s_left, s_right, input s_ready);
  modport slave  (input s_valid, s_left, s_right, output s_ready);
endinterface

// File: rtl/pt8211_stereo_fifo_tx.sv
// Stereo serial-audio DAC transmitter: L/R pair FIFO feeding a BCK/WS/DIN
// serialiser for PT8211 (FORMAT=0) or I2S (FORMAT=1) DACs, with underrun handling.
module pt8211_stereo_fifo_tx #(
  parameter int DATA_W        = 16,
  parameter int CLK_DIV       = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int FORMAT        = 0,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                            clk_27mhz,
  input  logic                            reset_n,
  input  logic                            enable,
  pt8211_stereo_fifo_tx_if.slave          s_in,
  output logic                            bck,
  output logic                            ws,
  output logic                            din,
  output logic                            frame_start,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int FW = 2 * DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(FW);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [FW-1:0] last_pair;
  logic [FW-1:0] shifter;
  logic [PW-1:0] presc;
  logic [BW-1:0] bit_cnt;
  logic          dly_bit;

  logic          fifo_empty, fifo_full, push, pop;
  logic          tick, upd, load;
  logic [BW-1:0] bit_cnt_nxt;
  logic [FW-1:0] load_pair, load_word;
  logic          frame_bit;

  always_comb begin
    fifo_level     = wr_ptr - rd_ptr;
    fifo_empty     = (wr_ptr == rd_ptr);
    fifo_full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
    s_in.s_ready   = !fifo_full;
    push           = s_in.s_valid && !fifo_full;
    tick           = enable && (presc == PW'(CLK_DIV - 1));
    upd            = tick && bck;
    bit_cnt_nxt    = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
    load           = upd && (bit_cnt_nxt == '0);
    // empty is judged before this clock's push, so a same-cycle push never bypasses
    pop            = load && !fifo_empty;
    if (!fifo_empty)
      load_pair = mem[rd_ptr[AW-1:0]];
    else if (UNDERRUN_ZERO != 0)
      load_pair = '0;
    else
      load_pair = last_pair;
    load_word      = (FORMAT != 0) ? load_pair
                                   : {load_pair[DATA_W-1:0], load_pair[FW-1:DATA_W]};
    frame_bit      = load ? load_word[FW-1] : shifter[FW-1];
  end

  always_ff @(posedge clk_27mhz) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {s_in.s_left, s_in.s_right};
  end

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      last_pair   <= '0;
      shifter     <= '0;
      presc       <= '0;
      bit_cnt     <= BW'(FW - 1);
      dly_bit     <= 1'b0;
      bck         <= 1'b0;
      ws          <= 1'b0;
      din         <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + (AW+1)'(1);
        last_pair <= load_pair;
      end
      frame_start <= load;
      underrun    <= load && fifo_empty;

      if (!enable) begin
        presc   <= '0;
        bit_cnt <= BW'(FW - 1);
        dly_bit <= 1'b0;
        bck     <= 1'b0;
        ws      <= 1'b0;
        din     <= 1'b0;
      end else begin
        if (tick) begin
          presc <= '0;
          bck   <= ~bck;
        end else begin
          presc <= presc + PW'(1);
        end
        if (upd) begin
          bit_cnt <= bit_cnt_nxt;
          ws      <= (bit_cnt_nxt >= BW'(DATA_W));
          // I2S: din lags the frame by one BCK through dly_bit
          din     <= (FORMAT != 0) ? dly_bit : frame_bit;
          dly_bit <= frame_bit;
          shifter <= load ? {load_word[FW-2:0], 1'b0} : {shifter[FW-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_pt8211_stereo_fifo_tx.sv
// Directed bench: PT8211/repeat and I2S/zero instances run in lock-step on
// the same stream, checked against hand-built expected frame words.
module tb_pt8211_stereo_fifo_tx;
  localparam int DATA_W = 16;

  logic clk_27mhz = 1'b0;
  logic reset_n   = 1'b0;
  logic enable    = 1'b0;
  always #18 clk_27mhz = ~clk_27mhz;

  pt8211_stereo_fifo_tx_if #(.DATA_W(DATA_W)) s0 ();
  pt8211_stereo_fifo_tx_if #(.DATA_W(DATA_W)) s1 ();

  logic bck0, ws0, din0, fs0, ur0;
  logic bck1, ws1, din1, fs1, ur1;
  logic [2:0] lvl0, lvl1;

  pt8211_stereo_fifo_tx #(.DATA_W(16), .CLK_DIV(2), .FIFO_DEPTH(4), .FORMAT(0), .UNDERRUN_ZERO(0)) dut0 (
    .clk_27mhz(clk_27mhz), .reset_n(reset_n), .enable(enable), .s_in(s0.slave),
    .bck(bck0), .ws(ws0), .din(din0), .frame_start(fs0), .underrun(ur0), .fifo_level(lvl0));

  pt8211_stereo_fifo_tx #(.DATA_W(16), .CLK_DIV(2), .FIFO_DEPTH(4), .FORMAT(1), .UNDERRUN_ZERO(1)) dut1 (
    .clk_27mhz(clk_27mhz), .reset_n(reset_n), .enable(enable), .s_in(s1.slave),
    .bck(bck1), .ws(ws1), .din(din1), .frame_start(fs1), .underrun(ur1), .fifo_level(lvl1));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_27mhz);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] l, input logic [15:0] r);
    s0.s_valid = v; s0.s_left = l; s0.s_right = r;
    s1.s_valid = v; s1.s_left = l; s1.s_right = r;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!fs0 && n < 400);
  endtask

  // Called on a frame_start cycle; collects 32 update events, returns on the next frame_start.
  task automatic grab_frame(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic e_ur, input bit push_en,
                            input logic [15:0] pl, input logic [15:0] pr,
                            output logic [31:0] d1);
    logic [31:0] d0, w0, w1;
    logic pb;
    int cyc, ev;
    chk({tag, "_underrun"}, {ur0, ur1}, {e_ur, e_ur});
    d0 = {31'b0, din0}; d1 = {31'b0, din1};
    w0 = {31'b0, ws0};  w1 = {31'b0, ws1};
    pb = bck0; cyc = 0; ev = 1;
    while (cyc < 400) begin
      if (push_en && cyc == 127) drive(1'b1, pl, pr);
      step();
      cyc++;
      if (push_en && cyc == 128) drive(1'b0, 16'h0, 16'h0);
      if (fs0) break;
      if (pb && !bck0) begin
        d0 = {d0[30:0], din0}; d1 = {d1[30:0], din1};
        w0 = {w0[30:0], ws0};  w1 = {w1[30:0], ws1};
        ev++;
      end
      pb = bck0;
    end
    chk({tag, "_period"}, 64'(cyc), 64'd128);
    chk({tag, "_events"}, 64'(ev), 64'd32);
    chk({tag, "_din_pt8211"}, d0, e0);
    chk({tag, "_din_i2s"}, d1, e1);
    chk({tag, "_ws"}, {w0, w1}, {32'h0000FFFF, 32'h0000FFFF});
  endtask

  localparam logic [15:0] L1 = 16'h1234, R1 = 16'hA5C3;
  localparam logic [15:0] L2 = 16'h8001, R2 = 16'h7FFE;
  localparam logic [15:0] L3 = 16'h3C5A, R3 = 16'hFFFF;

  initial begin
    int n, ev, cnt;
    logic pb;
    logic [31:0] d1;
    drive(1'b0, 16'h0, 16'h0);
    step(); step(); step();
    chk("reset_pins", {bck0, ws0, din0, bck1, ws1, din1}, 6'b0);
    chk("reset_pulses", {fs0, ur0, fs1, ur1}, 4'b0);
    chk("reset_level", {lvl0, lvl1}, 6'b0);
    chk("reset_ready", {s0.s_ready, s1.s_ready}, 2'b11);

    @(negedge clk_27mhz);
    reset_n = 1'b1;
    step(); step();
    chk("idle_pins", {bck0, ws0, din0, fs0, ur0}, 5'b0);

    drive(1'b1, L1, R1); step();
    drive(1'b1, L2, R2); step();
    drive(1'b0, 16'h0, 16'h0);
    chk("push_level", {lvl0, lvl1}, {3'd2, 3'd2});

    enable = 1'b1;
    wait_fs(n);
    chk("first_load_latency", 64'(n), 64'd4);
    chk("first_load_level", {lvl0, lvl1}, {3'd1, 3'd1});
    chk("first_load_fs_both", {fs0, fs1}, 2'b11);

    grab_frame("f1", {R1, L1}, {1'b0, L1, R1[15:1]}, 1'b0, 0, 16'h0, 16'h0, d1);
    grab_frame("f2", {R2, L2}, {R1[0], L2, R2[15:1]}, 1'b0, 0, 16'h0, 16'h0, d1);
    chk("i2s_l_msb_ev1", d1[30], 1'b1);
    chk("i2s_r_msb_ev17", d1[14], 1'b0);
    grab_frame("f3_underrun", {R2, L2}, {R2[0], 31'b0}, 1'b1, 1, L3, R3, d1);
    chk("push_on_load_level", {lvl0, lvl1}, {3'd1, 3'd1});
    grab_frame("f4_underrun", {R2, L2}, 32'h0, 1'b1, 0, 16'h0, 16'h0, d1);
    grab_frame("f5_late_pair", {R3, L3}, {1'b0, L3, R3[15:1]}, 1'b0, 0, 16'h0, 16'h0, d1);
    chk("f6_underrun", {ur0, ur1}, 2'b11);

    pb = bck0; ev = 0; cnt = 0;
    while (ev < 9 && cnt < 200) begin
      step();
      cnt++;
      if (pb && !bck0) ev++;
      pb = bck0;
    end
    step(); step();
    chk("mid_frame_bck_din", {bck0, din0}, 2'b11);
    enable = 1'b0;
    step();
    chk("disable_pins", {bck0, ws0, din0, bck1, ws1, din1}, 6'b0);
    chk("disable_pulses", {fs0, ur0, fs1, ur1}, 4'b0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      step();
    end
    drive(1'b0, 16'h0, 16'h0);
    chk("full_level", {lvl0, lvl1}, {3'd4, 3'd4});
    chk("full_ready", {s0.s_ready, s1.s_ready}, 2'b00);
    step(); step();
    chk("idle_no_load", {fs0, ur0, lvl0}, {2'b00, 3'd4});

    enable = 1'b1;
    wait_fs(n);
    chk("reenable_latency", 64'(n), 64'd4);
    chk("full_pop_ready", {s0.s_ready, lvl0}, {1'b1, 3'd3});
    grab_frame("f_bp", {16'h2000, 16'h1000}, {1'b0, 16'h1000, 15'h1000}, 1'b0, 0,
               16'h0, 16'h0, d1);
    chk("bp_level", {lvl0, lvl1}, {3'd2, 3'd2});

    step(); step(); step();
    #5;
    reset_n = 1'b0;
    #1;
    chk("async_reset_pins", {bck0, ws0, din0, fs0, ur0, bck1, ws1, din1}, 8'b0);
    chk("async_reset_level", {lvl0, lvl1, s0.s_ready}, {3'd0, 3'd0, 1'b1});
    @(negedge clk_27mhz);
    reset_n = 1'b1;
    wait_fs(n);
    chk("post_reset_latency", 64'(n), 64'd4);
    chk("post_reset_underrun", {ur0, ur1, lvl0}, {2'b11, 3'd0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
